// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and EX load/store.
// Data accesses win, bounded by a streak limit so fetches never starve.
module mem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int EX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ex_req,
    input  logic              ex_rw,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rdata,
    input  logic              flush,
    output logic              ram_req,
    output logic              ram_rw,
    output logic [DATA_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CW = $clog2(EX_STREAK + 1);
    localparam logic [CW-1:0] STREAK_MAX = CW'(EX_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_EX,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic              req_q, req_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              if_valid_q, if_valid_d;
    logic              ex_valid_q, ex_valid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ex_rdata_q, ex_rdata_d;

    logic grant_ex;
    logic grant_if;

    // A waiting fetch only loses while the EX streak is below its limit.
    assign grant_ex = ex_req && (!if_req || (cnt_q < STREAK_MAX));
    assign grant_if = if_req && !grant_ex;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        req_d      = req_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_valid_d = 1'b0;
        ex_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        ex_rdata_d = ex_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant_ex) begin
                    state_d = BUSY_EX;
                    req_d   = 1'b1;
                    rw_d    = ex_rw;
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    if (!if_req) begin
                        cnt_d = '0;
                    end else if (cnt_q < STREAK_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (grant_if) begin
                    state_d = BUSY_IF;
                    req_d   = 1'b1;
                    rw_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    cnt_d   = '0;
                end
            end
            BUSY_IF: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (ram_ack) begin
                    state_d    = RESP;
                    req_d      = 1'b0;
                    if_rdata_d = ram_rdata;
                    // A flush landing with the ack still kills the result.
                    if_valid_d = !(drop_q || flush);
                end
            end
            BUSY_EX: begin
                if (ram_ack) begin
                    state_d    = RESP;
                    req_d      = 1'b0;
                    ex_rdata_d = rw_q ? '0 : ram_rdata;
                    ex_valid_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            req_q      <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_valid_q <= 1'b0;
            ex_valid_q <= 1'b0;
            if_rdata_q <= '0;
            ex_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            req_q      <= req_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_valid_q <= if_valid_d;
            ex_valid_q <= ex_valid_d;
            if_rdata_q <= if_rdata_d;
            ex_rdata_q <= ex_rdata_d;
        end
    end

    assign ram_req   = req_q;
    assign ram_rw    = rw_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign if_valid  = if_valid_q;
    assign if_rdata  = if_rdata_q;
    assign ex_valid  = ex_valid_q;
    assign ex_rdata  = ex_rdata_q;

endmodule
